// File: rtl/pipeline_pkg.sv
// Shared pipeline definitions: RV32I opcode constants, the NOP encoding and
// the fetch-buffer entry type.
package pipeline_pkg;

    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;

    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
    } fb_entry_t;

    function automatic logic is_ctrl(input logic [6:0] op);
        return (op == OP_BRANCH) || (op == OP_JAL) || (op == OP_JALR);
    endfunction

endpackage

// File: rtl/dual_fetch_buffer_if.sv
// Fetch/decode boundary of the dual-issue front end: redirect, instruction
// memory port and the two decode lanes.
interface dual_fetch_buffer_if;

    logic        redirect_i;
    logic [31:0] redirect_pc_i;
    logic [31:0] imem_addr_o;
    logic [31:0] imem_rd0_i;
    logic [31:0] imem_rd1_i;
    logic        ready1_i;
    logic        ready2_i;
    logic        valid1_o;
    logic [31:0] pc1_o;
    logic [31:0] instr1_o;
    logic        valid2_o;
    logic [31:0] pc2_o;
    logic [31:0] instr2_o;

    modport slave (
        input  redirect_i, redirect_pc_i, imem_rd0_i, imem_rd1_i, ready1_i, ready2_i,
        output imem_addr_o, valid1_o, pc1_o, instr1_o, valid2_o, pc2_o, instr2_o
    );

    modport master (
        output redirect_i, redirect_pc_i, imem_rd0_i, imem_rd1_i, ready1_i, ready2_i,
        input  imem_addr_o, valid1_o, pc1_o, instr1_o, valid2_o, pc2_o, instr2_o
    );

endinterface

// File: rtl/pair_check.sv
// Decides whether instr_b may issue alongside instr_a in the same cycle; all
// intra-pair hazards are resolved here by splitting the pair.
module pair_check
    import pipeline_pkg::*;
(
    input  logic [31:0] instr_a_i,
    input  logic [31:0] instr_b_i,
    output logic        pair_ok_o
);

    logic [6:0] op_a, op_b;
    logic [4:0] rd_a, rd_b, rs1_b, rs2_b;
    logic       a_writes, raw_dep, mem_order;
    logic       unused_bits;

    assign op_a  = instr_a_i[6:0];
    assign rd_a  = instr_a_i[11:7];
    assign op_b  = instr_b_i[6:0];
    assign rd_b  = instr_b_i[11:7];
    assign rs1_b = instr_b_i[19:15];
    assign rs2_b = instr_b_i[24:20];

    // Raw field compare regardless of format: conservative splits are cheap.
    assign a_writes  = (op_a != OP_BRANCH) && (op_a != OP_STORE) && (rd_a != 5'd0);
    assign raw_dep   = a_writes && ((rs1_b == rd_a) || (rs2_b == rd_a) || (rd_b == rd_a));
    assign mem_order = (op_a == OP_STORE) && (op_b == OP_LOAD);

    assign pair_ok_o = !(is_ctrl(op_a) || raw_dep || mem_order || is_ctrl(op_b));

    assign unused_bits = ^{instr_a_i[31:12], instr_b_i[31:25], instr_b_i[14:12]};

endmodule

// File: rtl/dual_fetch_buffer.sv
// Dual-word fetch stage plus in-order instruction queue feeding two decode
// lanes; lane 2 is withheld whenever the head pair cannot issue together.
module dual_fetch_buffer
    import pipeline_pkg::*;
#(
    parameter int          DEPTH    = 8,
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic                clk,
    input  logic                rst,
    dual_fetch_buffer_if.slave  bus
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    fb_entry_t       mem_q [DEPTH];
    logic [AW-1:0]   head_q, head_d, tail_q, tail_d;
    logic [AW-1:0]   head1, tail1;
    logic [CW-1:0]   count_q, count_d;
    logic [31:0]     fpc_q, fpc_d;
    fb_entry_t       e1, e2;
    logic            valid1, valid2, pair_ok;
    logic            enq, pop1, pop2;
    logic            unused_rpc;

    assign head1 = head_q + 1'b1;
    assign tail1 = tail_q + 1'b1;
    assign e1    = mem_q[head_q];
    assign e2    = mem_q[head1];

    pair_check u_pair (
        .instr_a_i (e1.instr),
        .instr_b_i (e2.instr),
        .pair_ok_o (pair_ok)
    );

    assign valid1 = (count_q != '0);
    assign valid2 = (count_q >= CW'(2)) && pair_ok;

    // Enqueue looks at the registered count only, keeping ready off the imem path.
    assign enq  = !bus.redirect_i && (count_q <= CW'(DEPTH - 2));
    assign pop1 = valid1 && bus.ready1_i && !bus.redirect_i;
    assign pop2 = pop1 && valid2 && bus.ready2_i;

    assign bus.imem_addr_o = fpc_q;
    assign bus.valid1_o    = valid1;
    assign bus.pc1_o       = valid1 ? e1.pc    : 32'h0;
    assign bus.instr1_o    = valid1 ? e1.instr : NOP_INSTR;
    assign bus.valid2_o    = valid2;
    assign bus.pc2_o       = valid2 ? e2.pc    : 32'h0;
    assign bus.instr2_o    = valid2 ? e2.instr : NOP_INSTR;

    assign unused_rpc = ^bus.redirect_pc_i[1:0];

    always_comb begin
        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q;
        fpc_d   = fpc_q;
        if (bus.redirect_i) begin
            head_d  = '0;
            tail_d  = '0;
            count_d = '0;
            fpc_d   = {bus.redirect_pc_i[31:2], 2'b00};
        end else begin
            head_d  = head_q + AW'(pop1) + AW'(pop2);
            count_d = count_q + (enq ? CW'(2) : CW'(0)) - CW'(pop1) - CW'(pop2);
            if (enq) begin
                tail_d = tail_q + AW'(2);
                fpc_d  = fpc_q + 32'd8;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
            fpc_q   <= RESET_PC;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
            fpc_q   <= fpc_d;
        end
    end

    // Payload storage needs no reset: count gates every read.
    always_ff @(posedge clk) begin
        if (enq) begin
            mem_q[tail_q] <= '{pc: fpc_q,         instr: bus.imem_rd0_i};
            mem_q[tail1]  <= '{pc: fpc_q + 32'd4, instr: bus.imem_rd1_i};
        end
    end

endmodule

// File: tb/tb_dual_fetch_buffer.sv
// Directed, table-driven bench for dual_fetch_buffer with a combinational
// instruction memory holding hand-placed pairing cases.
module tb_dual_fetch_buffer;

    localparam logic [31:0] NOP = 32'h0000_0013;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    dual_fetch_buffer_if bus ();

    dual_fetch_buffer #(.DEPTH(8), .RESET_PC(32'h0)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    logic [31:0] prog [0:1023];
    logic [31:0] addr4;
    assign addr4          = bus.imem_addr_o + 32'd4;
    assign bus.imem_rd0_i = prog[bus.imem_addr_o[11:2]];
    assign bus.imem_rd1_i = prog[addr4[11:2]];

    typedef struct {
        logic        redir;
        logic [31:0] rpc;
        logic        r1, r2;
        logic [31:0] addr;
        logic        lanes;
        logic        v1;
        logic [31:0] pc1;
        logic        v2;
        logic [31:0] pc2;
    } vec_t;

    vec_t tbl[$];
    int   n_vec  = 0;
    int   n_miss = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic chk_lanes(input string tag, input logic v1, input logic [31:0] pc1,
                             input logic v2, input logic [31:0] pc2);
        logic [31:0] pa, pb;
        pa = pc1;
        pb = pc2;
        chk({tag, ".valid1"}, 32'(bus.valid1_o), 32'(v1));
        chk({tag, ".pc1"},    bus.pc1_o,    v1 ? pc1 : 32'h0);
        chk({tag, ".instr1"}, bus.instr1_o, v1 ? prog[pa[11:2]] : NOP);
        chk({tag, ".valid2"}, 32'(bus.valid2_o), 32'(v2));
        chk({tag, ".pc2"},    bus.pc2_o,    v2 ? pc2 : 32'h0);
        chk({tag, ".instr2"}, bus.instr2_o, v2 ? prog[pb[11:2]] : NOP);
    endtask

    // Drive at the falling edge, check 1ns later, then advance one cycle.
    task automatic step(input string tag, input logic redir, input logic [31:0] rpc,
                        input logic r1, input logic r2, input logic [31:0] addr,
                        input logic lanes, input logic v1, input logic [31:0] pc1,
                        input logic v2, input logic [31:0] pc2);
        bus.redirect_i    = redir;
        bus.redirect_pc_i = rpc;
        bus.ready1_i      = r1;
        bus.ready2_i      = r2;
        #1;
        chk({tag, ".addr"}, bus.imem_addr_o, addr);
        if (lanes) chk_lanes(tag, v1, pc1, v2, pc2);
        @(negedge clk);
    endtask

    task automatic row(input logic redir, input logic [31:0] rpc, input logic [31:0] addr,
                       input logic lanes, input logic v1, input logic [31:0] pc1,
                       input logic v2, input logic [31:0] pc2);
        tbl.push_back('{redir, rpc, 1'b1, 1'b1, addr, lanes, v1, pc1, v2, pc2});
    endtask

    initial begin
        for (int i = 0; i < 1024; i++) prog[i] = {20'd0, 5'(i % 31 + 1), 7'h13};
        prog[32'h200 >> 2] = 32'h0010_0293;  // addi x5,x0,1
        prog[32'h204 >> 2] = 32'h0052_8333;  // add  x6,x5,x5
        prog[32'h300 >> 2] = 32'h0000_0063;  // beq  x0,x0,0
        prog[32'h400 >> 2] = 32'h0000_2023;  // sw   x0,0(x0)
        prog[32'h404 >> 2] = 32'h0000_2503;  // lw   x10,0(x0)
        prog[32'h500 >> 2] = 32'h0020_8033;  // add  x0,x1,x2
        prog[32'h504 >> 2] = 32'h0000_01B3;  // add  x3,x0,x0
        prog[32'h604 >> 2] = 32'h0000_006F;  // jal  x0,0

        bus.redirect_i    = 1'b0;
        bus.redirect_pc_i = 32'h0;
        bus.ready1_i      = 1'b1;
        bus.ready2_i      = 1'b1;

        // streaming, then each pairing case reached through a redirect
        row(0, 0,       32'h000, 1, 0, 0,       0, 0);
        row(0, 0,       32'h008, 1, 1, 32'h000, 1, 32'h004);
        row(0, 0,       32'h010, 1, 1, 32'h008, 1, 32'h00C);
        row(1, 32'h201, 32'h018, 0, 0, 0,       0, 0);
        row(0, 0,       32'h200, 1, 0, 0,       0, 0);
        row(0, 0,       32'h208, 1, 1, 32'h200, 0, 0);
        row(0, 0,       32'h210, 1, 1, 32'h204, 1, 32'h208);
        row(1, 32'h300, 32'h218, 0, 0, 0,       0, 0);
        row(0, 0,       32'h300, 1, 0, 0,       0, 0);
        row(0, 0,       32'h308, 1, 1, 32'h300, 0, 0);
        row(0, 0,       32'h310, 1, 1, 32'h304, 1, 32'h308);
        row(1, 32'h400, 32'h318, 0, 0, 0,       0, 0);
        row(0, 0,       32'h400, 1, 0, 0,       0, 0);
        row(0, 0,       32'h408, 1, 1, 32'h400, 0, 0);
        row(0, 0,       32'h410, 1, 1, 32'h404, 1, 32'h408);
        row(1, 32'h500, 32'h418, 0, 0, 0,       0, 0);
        row(0, 0,       32'h500, 1, 0, 0,       0, 0);
        row(0, 0,       32'h508, 1, 1, 32'h500, 1, 32'h504);
        row(1, 32'h600, 32'h510, 0, 0, 0,       0, 0);
        row(0, 0,       32'h600, 1, 0, 0,       0, 0);
        row(0, 0,       32'h608, 1, 1, 32'h600, 0, 0);
        row(0, 0,       32'h610, 1, 1, 32'h604, 0, 0);
        row(0, 0,       32'h618, 1, 1, 32'h608, 1, 32'h60C);

        #12;
        chk("reset.addr", bus.imem_addr_o, 32'h0);
        chk_lanes("reset", 0, 0, 0, 0);
        @(negedge clk);
        rst = 1'b0;

        foreach (tbl[i])
            step($sformatf("vec%0d", i), tbl[i].redir, tbl[i].rpc, tbl[i].r1, tbl[i].r2,
                 tbl[i].addr, tbl[i].lanes, tbl[i].v1, tbl[i].pc1, tbl[i].v2, tbl[i].pc2);

        // stall until full; fetch stops and the queue wraps
        step("stall.redir", 1, 32'h700, 0, 0, 32'h620, 0, 0, 0, 0, 0);
        for (int k = 1; k <= 10; k++)
            step($sformatf("stall%0d", k), 0, 0, 0, 0, 32'h700 + 32'(8 * ((k - 1 < 4) ? k - 1 : 4)),
                 1, k >= 2, 32'h700, k >= 2, 32'h704);

        // drain: every entry comes out once, in order
        for (int k = 0; k < 8; k++)
            step($sformatf("drain%0d", k), 0, 0, 1, 1, (k == 0) ? 32'h720 : 32'h720 + 32'(8 * (k - 1)),
                 1, 1, 32'h700 + 32'(8 * k), 1, 32'h704 + 32'(8 * k));

        // refill to full, then redirect with both lanes ready
        step("refill0", 0, 0, 0, 0, 32'h758, 1, 1, 32'h740, 1, 32'h744);
        step("refill1", 0, 0, 0, 0, 32'h760, 1, 1, 32'h740, 1, 32'h744);
        step("refill2", 0, 0, 0, 0, 32'h760, 1, 1, 32'h740, 1, 32'h744);
        step("fullredir", 1, 32'h100, 1, 1, 32'h760, 0, 0, 0, 0, 0);
        step("redir.n1", 0, 0, 1, 1, 32'h100, 1, 0, 0, 0, 0);

        // lane 2 ready alone never pops
        step("r2only0", 0, 0, 0, 1, 32'h108, 1, 1, 32'h100, 1, 32'h104);
        step("r2only1", 0, 0, 0, 1, 32'h110, 1, 1, 32'h100, 1, 32'h104);
        bus.ready1_i = 1'b0;
        bus.ready2_i = 1'b1;
        #1;
        chk("r2only2.addr", bus.imem_addr_o, 32'h118);
        chk_lanes("r2only2", 1, 32'h100, 1, 32'h104);

        // asynchronous reset mid-stream
        #2 rst = 1'b1;
        #1;
        chk("arst.addr", bus.imem_addr_o, 32'h0);
        chk_lanes("arst", 0, 0, 0, 0);
        @(negedge clk);
        rst = 1'b0;
        step("post0", 0, 0, 1, 1, 32'h000, 1, 0, 0, 0, 0);
        step("post1", 0, 0, 1, 1, 32'h008, 1, 1, 32'h000, 1, 32'h004);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
